// File: rtl/memory_cycle_stage.sv
// RV32I memory stage: byte-enabled word RAM for loads/stores plus the MEM/WB
// pipeline register that feeds the writeback mux.
module memory_cycle_stage #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  input  logic        FlushW,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [31:0] PCPlus4W,
  output logic        MisalignW
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] SRC_LOAD = 2'b01;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wordIdx;
  logic [1:0]        byteOff;
  logic              isByte, isHalf, isWord, misPattern, validOp, isLoad, misaligned;
  logic [3:0]        byteEn;
  logic [31:0]       storeLanes;
  logic [31:0]       readWord;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;
  logic [31:0]       loadData;
  logic              unusedAddrBits;

  // Upper address bits are dropped on purpose: the RAM aliases modulo 4*DEPTH bytes.
  assign wordIdx        = ALUResultM[ADDR_W+1:2];
  assign byteOff        = ALUResultM[1:0];
  assign unusedAddrBits = ^ALUResultM[31:ADDR_W+2];

  assign isByte     = (funct3M == F3_B) || (funct3M == F3_BU);
  assign isHalf     = (funct3M == F3_H) || (funct3M == F3_HU);
  assign isWord     = (funct3M == F3_W);
  assign misPattern = (isHalf && byteOff[0]) || (isWord && (byteOff != 2'b00));
  assign validOp    = (isByte || isHalf || isWord) && !misPattern;
  assign isLoad     = (ResultSrcM == SRC_LOAD);
  assign misaligned = (isLoad || MemWriteM) && misPattern;

  // Store lanes are replicated so each enabled byte lane sees the right source byte.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    byteEn     = 4'b0000;
    storeLanes = WriteDataM;
    if (MemWriteM && validOp) begin
      if (isByte) begin
        byteEn     = 4'b0001 << byteOff;
        storeLanes = {4{WriteDataM[7:0]}};
      end else if (isHalf) begin
        byteEn     = 4'b0011 << byteOff;
        storeLanes = {2{WriteDataM[15:0]}};
      end else begin
        byteEn     = 4'b1111;
      end
    end
  end

  // NOTE: the RAM array has no reset; gating writes with rst keeps reset from corrupting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeLanes[8*i +: 8];
      end
    end
  end

  // Combinational read gives store-to-load forwarding for free on the next cycle.
  assign readWord = mem[wordIdx];
  assign loadByte = readWord[{byteOff, 3'b000} +: 8];
  assign loadHalf = readWord[{byteOff[1], 4'b0000} +: 16];

  always_comb begin
    loadData = '0;
    case (funct3M)
      F3_B:    loadData = {{24{loadByte[7]}}, loadByte};
      F3_H:    loadData = {{16{loadHalf[15]}}, loadHalf};
      F3_W:    loadData = readWord;
      F3_BU:   loadData = {24'd0, loadByte};
      F3_HU:   loadData = {16'd0, loadHalf};
      default: loadData = '0;
    endcase
    if (misPattern) loadData = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all W registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ReadDataW  <= 32'd0;
      ALUResultW <= 32'd0;
      PCPlus4W   <= 32'd0;
      MisalignW  <= 1'b0;
    end else if (FlushW) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RdW        <= 5'd0;
      ReadDataW  <= 32'd0;
      ALUResultW <= 32'd0;
      PCPlus4W   <= 32'd0;
      MisalignW  <= 1'b0;
    end else begin
      RegWriteW  <= RegWriteM && !(isLoad && misPattern);
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
      ReadDataW  <= loadData;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      MisalignW  <= misaligned;
    end
  end

endmodule

// File: tb/tb_memory_cycle_stage.sv
// Self-checking bench for memory_cycle_stage: directed scenarios plus randomized
// traffic compared against a byte-array memory model.
module tb_memory_cycle_stage;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, FlushW;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic        RegWriteW, MisalignW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;

  int total = 0;
  int bad   = 0;

  logic [7:0] model [NBYTES];

  memory_cycle_stage #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .funct3M(funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .FlushW(FlushW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
    .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W),
    .MisalignW(MisalignW)
  );

  always #5 clk = ~clk;

  function automatic logic is_mis(input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd1 || f3 == 3'd5) return addr[0];
    if (f3 == 3'd2) return addr[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic is_undef(input logic [2:0] f3);
    return f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    a = int'(addr % NBYTES);
    if (is_mis(f3, addr) || is_undef(f3)) return 32'd0;
    b = model[a];
    h = (f3 == 3'd1 || f3 == 3'd5) ? {model[a+1], model[a]} : 16'd0;
    w = (f3 == 3'd2) ? {model[a+3], model[a+2], model[a+1], model[a]} : 32'd0;
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd2:    return w;
      3'd4:    return {24'd0, b};
      default: return {16'd0, h};
    endcase
  endfunction

  function automatic void model_store(input logic [2:0] f3, input logic [31:0] addr,
                                      input logic [31:0] data);
    int a;
    a = int'(addr % NBYTES);
    if (is_mis(f3, addr) || is_undef(f3)) return;
    model[a] = data[7:0];
    if (f3 == 3'd1 || f3 == 3'd5 || f3 == 3'd2) model[a+1] = data[15:8];
    if (f3 == 3'd2) begin
      model[a+2] = data[23:16];
      model[a+3] = data[31:24];
    end
  endfunction

  // Apply one M-stage instruction, let the edge pass, and leave time at edge+1.
  task automatic drive(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc, input logic fl);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3; RdM = rd;
    ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc; FlushW = fl;
    @(posedge clk);
    if (rst && mw) model_store(f3, alu, wd);
    #1;
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    drive(1'b0, 1'b1, 2'b00, f3, 5'd0, addr, data, 32'h0000_0200, 1'b0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr);
    drive(1'b1, 1'b0, 2'b01, f3, 5'd3, addr, $urandom, 32'h0000_0104, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    #1;
    total++;
    if ({RegWriteW, ResultSrcW, RdW, ReadDataW, ALUResultW, PCPlus4W, MisalignW} !== 105'd0) begin
      bad++;
      $display("FAIL reset_por: RdW=%0d ReadDataW=%h ALUResultW=%h want all 0", RdW, ReadDataW, ALUResultW);
    end
    #10 rst = 1'b1;
    for (int i = 0; i < 16; i++) st(3'd2, 32'(4 * i), 32'd0);

    st(3'd2, 32'h14, 32'h1357_9BDF);
    drive(1'b1, 1'b0, 2'b01, 3'd2, 5'd7, 32'h14, 32'd0, 32'h0000_0100, 1'b0);
    total++;
    if (ReadDataW !== 32'h1357_9BDF || RdW !== 5'd7 || PCPlus4W !== 32'h100) begin
      bad++;
      $display("FAIL pre_reset_load: ReadDataW=%h RdW=%0d PCPlus4W=%h want 13579bdf 7 100", ReadDataW, RdW, PCPlus4W);
    end
    #3 rst = 1'b0;
    #1;
    total++;
    if ({RegWriteW, ResultSrcW, RdW, ReadDataW, ALUResultW, PCPlus4W, MisalignW} !== 105'd0) begin
      bad++;
      $display("FAIL reset_async: RegWriteW=%b RdW=%0d ReadDataW=%h want all 0", RegWriteW, RdW, ReadDataW);
    end
    drive(1'b1, 1'b1, 2'b01, 3'd2, 5'd4, 32'h14, 32'hFFFF_FFFF, 32'h44, 1'b0);
    total++;
    if ({RegWriteW, ResultSrcW, RdW, ReadDataW, ALUResultW, PCPlus4W, MisalignW} !== 105'd0) begin
      bad++;
      $display("FAIL reset_hold: RegWriteW=%b ReadDataW=%h ALUResultW=%h want all 0", RegWriteW, ReadDataW, ALUResultW);
    end
    #3 rst = 1'b1;
    ld(3'd2, 32'h14);
    total++;
    if (ReadDataW !== 32'h1357_9BDF) begin
      bad++;
      $display("FAIL reset_ram_retained: got=%h want=13579bdf", ReadDataW);
    end
  endtask

  task automatic test_store_load();
    st(3'd2, 32'h10, 32'hDEAD_BEEF);
    total++;
    if (RegWriteW !== 1'b0 || MisalignW !== 1'b0 || ALUResultW !== 32'h10) begin
      bad++;
      $display("FAIL sw_wslot: RegWriteW=%b MisalignW=%b ALUResultW=%h want 0 0 10", RegWriteW, MisalignW, ALUResultW);
    end
    ld(3'd2, 32'h10);
    total++;
    if (ReadDataW !== 32'hDEAD_BEEF || RegWriteW !== 1'b1 || ResultSrcW !== 2'b01 || RdW !== 5'd3) begin
      bad++;
      $display("FAIL store_to_load: ReadDataW=%h RegWriteW=%b ResultSrcW=%b RdW=%0d want deadbeef 1 01 3",
               ReadDataW, RegWriteW, ResultSrcW, RdW);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    st(3'd2, 32'h10, 32'h80FF_7F01);
    for (int i = 0; i < 4; i++) begin
      ld(f3s[i], adrs[i]);
      total++;
      if (ReadDataW !== exps[i]) begin
        bad++;
        $display("FAIL load_ext[%0d] f3=%0d addr=%h: got=%h want=%h", i, f3s[i], adrs[i], ReadDataW, exps[i]);
      end
    end
  endtask

  task automatic test_partial_store();
    st(3'd0, 32'h21, 32'h1234_56AA);
    ld(3'd2, 32'h20);
    total++;
    if (ReadDataW !== 32'h0000_AA00) begin
      bad++;
      $display("FAIL sb_lane: got=%h want=0000aa00", ReadDataW);
    end
    st(3'd1, 32'h22, 32'hFFFF_1234);
    ld(3'd2, 32'h20);
    total++;
    if (ReadDataW !== 32'h1234_AA00) begin
      bad++;
      $display("FAIL sh_lanes: got=%h want=1234aa00", ReadDataW);
    end
  endtask

  task automatic test_misalign();
    st(3'd2, 32'h31, 32'hFFFF_FFFF);
    total++;
    if (MisalignW !== 1'b1 || RegWriteW !== 1'b0) begin
      bad++;
      $display("FAIL sw_misalign_flag: MisalignW=%b RegWriteW=%b want 1 0", MisalignW, RegWriteW);
    end
    st(3'd3, 32'h30, 32'hFFFF_FFFF);
    total++;
    if (MisalignW !== 1'b0) begin
      bad++;
      $display("FAIL undef_store_flag: MisalignW=%b want 0", MisalignW);
    end
    ld(3'd2, 32'h30);
    total++;
    if (ReadDataW !== 32'd0) begin
      bad++;
      $display("FAIL suppressed_stores: got=%h want=00000000", ReadDataW);
    end
    ld(3'd1, 32'h33);
    total++;
    if (RegWriteW !== 1'b0 || ReadDataW !== 32'd0 || MisalignW !== 1'b1) begin
      bad++;
      $display("FAIL lh_misalign: RegWriteW=%b ReadDataW=%h MisalignW=%b want 0 0 1", RegWriteW, ReadDataW, MisalignW);
    end
    ld(3'd0, 32'h33);
    total++;
    if (RegWriteW !== 1'b1 || MisalignW !== 1'b0) begin
      bad++;
      $display("FAIL lb_odd_ok: RegWriteW=%b MisalignW=%b want 1 0", RegWriteW, MisalignW);
    end
  endtask

  task automatic test_wrap();
    st(3'd2, 32'(NBYTES + 8), 32'h0000_0005);
    ld(3'd2, 32'h8);
    total++;
    if (ReadDataW !== 32'h0000_0005) begin
      bad++;
      $display("FAIL addr_wrap: got=%h want=00000005", ReadDataW);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 2'b10, 3'd2, 5'd9, 32'h0C, 32'hCAFE_F00D, 32'h44, 1'b1);
    total++;
    if ({RegWriteW, ResultSrcW, RdW, ReadDataW, ALUResultW, PCPlus4W, MisalignW} !== 105'd0) begin
      bad++;
      $display("FAIL flush_bubble: RegWriteW=%b RdW=%0d ALUResultW=%h PCPlus4W=%h want all 0",
               RegWriteW, RdW, ALUResultW, PCPlus4W);
    end
    ld(3'd2, 32'h0C);
    total++;
    if (ReadDataW !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL flush_store_lands: got=%h want=cafef00d", ReadDataW);
    end
  endtask

  task automatic test_random();
    logic [104:0] exp_w, got_w;
    logic [2:0]   f3;
    logic [31:0]  addr, wd, pc;
    logic [4:0]   rd;
    logic [1:0]   rs;
    logic         rw, mw, fl, mis, is_ld;
    int           op;
    for (int i = 0; i < 400; i++) begin
      op   = int'($urandom_range(0, 2));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom & 32'hFFFF_F03F;
      wd   = $urandom;
      pc   = $urandom;
      rd   = 5'($urandom_range(0, 31));
      rw   = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 9) == 0);
      mw   = (op == 0);
      rs   = (op == 1) ? 2'b01 : ((op == 2 && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b00);
      if (op == 0) rw = 1'b0;
      is_ld = (rs == 2'b01);
      mis   = is_mis(f3, addr);
      exp_w = fl ? 105'd0
                 : {rw & ~(is_ld & mis), rs, rd, model_load(f3, addr), addr, pc, (is_ld | mw) & mis};
      drive(rw, mw, rs, f3, rd, addr, wd, pc, fl);
      got_w = {RegWriteW, ResultSrcW, RdW, ReadDataW, ALUResultW, PCPlus4W, MisalignW};
      total++;
      if (got_w !== exp_w) begin
        bad++;
        $display("FAIL random[%0d] op=%0d f3=%0d addr=%h fl=%b: got rw=%b rd=%0d data=%h mis=%b want rw=%b rd=%0d data=%h mis=%b",
                 i, op, f3, addr, fl, got_w[104], got_w[101:97], got_w[96:65], got_w[0],
                 exp_w[104], exp_w[101:97], exp_w[96:65], exp_w[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_ext();
    test_partial_store();
    test_misalign();
    test_wrap();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
